// File: rtl/sar_channel_ctrl_pkg.sv
// Shared definitions for the per-channel SAR conversion controller.
//
// Contents:
//   state_e          : controller states (IDLE, SAMPLE, SET, CHECK, DONE)
//   *_DEF            : default field widths of the packed event word
//   event_w()        : total packed event width for a given field set
//   code_lsb()/ts_lsb()/ch_lsb() : bit offsets of the event fields
//
// Event word layout, MSB to LSB: {channel id, time stamp, ADC code}.
package sar_channel_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_SET,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int ADCBITS_DEF      = 6;
  localparam int TIME_STAMP_W_DEF = 24;
  localparam int CHANNEL_ID_W_DEF = 7;
  localparam int EVENT_W_DEF      = CHANNEL_ID_W_DEF + TIME_STAMP_W_DEF + ADCBITS_DEF;

  function automatic int event_w(input int ch_w, input int ts_w, input int adc_w);
    return ch_w + ts_w + adc_w;
  endfunction

  function automatic int code_lsb();
    return 0;
  endfunction

  function automatic int ts_lsb(input int adc_w);
    return adc_w;
  endfunction

  function automatic int ch_lsb(input int ts_w, input int adc_w);
    return ts_w + adc_w;
  endfunction

endpackage

// File: rtl/sar_channel_ctrl.sv
// Per-channel SAR conversion controller.
//
// On a rising hit edge while armed, latches the time stamp, holds the
// sample switch closed for SAMPLE_CYCLES clocks, then runs an MSB-first
// binary search driving dac_word/strobe and reading comp. The finished
// event {CHANNEL_ID, time stamp, code} is offered with valid/ready.
//
// Ports:
//   clk4x        : sole clock
//   reset        : synchronous, active-high reset
//   arm          : channel enable, only consulted in IDLE
//   hit          : discriminator level, rising edge triggers
//   timestamp    : free-running chip time stamp
//   comp         : comparator result, 1 means vin >= DAC
//   sample       : sample switch control
//   strobe       : comparator strobe, one cycle per trial
//   dac_word     : trial DAC code (final code while an event is held)
//   busy         : high whenever not in IDLE
//   hit_dropped  : one-cycle pulse when a rising hit edge is ignored
//   event_valid  : event available
//   event_ready  : arbiter accepts event
//   event_data   : {CHANNEL_ID, ts, code}, MSB to LSB
//
// All outputs come straight from registers.
module sar_channel_ctrl
  import sar_channel_ctrl_pkg::*;
#(
  parameter int ADCBITS       = ADCBITS_DEF,
  parameter int TIME_STAMP_W  = TIME_STAMP_W_DEF,
  parameter int CHANNEL_ID_W  = CHANNEL_ID_W_DEF,
  parameter int CHANNEL_ID    = 0,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic                                         clk4x,
  input  logic                                         reset,
  input  logic                                         arm,
  input  logic                                         hit,
  input  logic [TIME_STAMP_W-1:0]                      timestamp,
  input  logic                                         comp,
  output logic                                         sample,
  output logic                                         strobe,
  output logic [ADCBITS-1:0]                           dac_word,
  output logic                                         busy,
  output logic                                         hit_dropped,
  output logic                                         event_valid,
  input  logic                                         event_ready,
  output logic [CHANNEL_ID_W+TIME_STAMP_W+ADCBITS-1:0] event_data
);

  localparam int EVENT_W = event_w(CHANNEL_ID_W, TIME_STAMP_W, ADCBITS);
  localparam int KW      = (ADCBITS > 1) ? $clog2(ADCBITS) : 1;
  localparam int SW      = $clog2(SAMPLE_CYCLES + 1);

  state_e                    state_q, state_d;
  logic                      hit_q;
  logic                      sample_q, sample_d;
  logic                      strobe_q, strobe_d;
  logic [ADCBITS-1:0]        dac_q, dac_d;
  logic                      busy_q, busy_d;
  logic                      drop_q, drop_d;
  logic                      valid_q, valid_d;
  logic [EVENT_W-1:0]        data_q, data_d;
  logic [TIME_STAMP_W-1:0]   ts_q, ts_d;
  logic [ADCBITS-1:0]        result_q, result_d;
  logic [KW-1:0]             k_q, k_d;
  logic [SW-1:0]             scnt_q, scnt_d;

  logic                      trig;
  logic [ADCBITS-1:0]        final_code;

  assign trig = hit & ~hit_q;

  // On the last CHECK, bit 0 of result_q is still clear, so OR-ing in comp
  // yields the completed code one cycle before result_q holds it.
  assign final_code = result_q | ADCBITS'(comp);

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    strobe_d = 1'b0;
    dac_d    = dac_q;
    valid_d  = valid_q;
    data_d   = data_q;
    ts_d     = ts_q;
    result_d = result_q;
    k_d      = k_q;
    scnt_d   = scnt_q;
    drop_d   = trig && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (trig && arm) begin
          ts_d     = timestamp;
          sample_d = 1'b1;
          result_d = '0;
          scnt_d   = SW'(SAMPLE_CYCLES - 1);
          state_d  = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (scnt_q == '0) begin
          sample_d = 1'b0;
          k_d      = KW'(ADCBITS - 1);
          state_d  = ST_SET;
        end else begin
          scnt_d = scnt_q - SW'(1);
        end
      end

      ST_SET: begin
        dac_d    = result_q | (ADCBITS'(1) << k_q);
        strobe_d = 1'b1;
        state_d  = ST_CHECK;
      end

      ST_CHECK: begin
        result_d[k_q] = comp;
        if (k_q == '0) begin
          data_d  = {CHANNEL_ID_W'(CHANNEL_ID), ts_q, final_code};
          dac_d   = final_code;
          state_d = ST_DONE;
        end else begin
          k_d     = k_q - KW'(1);
          state_d = ST_SET;
        end
      end

      ST_DONE: begin
        // First DONE cycle raises valid; the handshake is judged on valid_q.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (event_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk4x) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hit_q    <= 1'b0;
      sample_q <= 1'b0;
      strobe_q <= 1'b0;
      dac_q    <= '0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ts_q     <= '0;
      result_q <= '0;
      k_q      <= '0;
      scnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      hit_q    <= hit;
      sample_q <= sample_d;
      strobe_q <= strobe_d;
      dac_q    <= dac_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ts_q     <= ts_d;
      result_q <= result_d;
      k_q      <= k_d;
      scnt_q   <= scnt_d;
    end
  end

  assign sample      = sample_q;
  assign strobe      = strobe_q;
  assign dac_word    = dac_q;
  assign busy        = busy_q;
  assign hit_dropped = drop_q;
  assign event_valid = valid_q;
  assign event_data  = data_q;

endmodule

// File: tb/tb_sar_channel_ctrl.sv
// Bench for sar_channel_ctrl: an ideal analog SAR front end (comparator
// against VCM + code*(VREF-VCM)/2^ADCBITS) plus a reference code model
// found by exhaustive search over all codes.
module tb_sar_channel_ctrl;

  localparam int AB  = 6;
  localparam int TW  = 24;
  localparam int CW  = 7;
  localparam int CH  = 4;
  localparam int SC  = 2;
  localparam int EW  = CW + TW + AB;
  localparam int LAT = 1 + SC + 2 * AB;

  logic          clk4x = 1'b0;
  logic          reset, arm, hit, comp, event_ready;
  logic [TW-1:0] timestamp = '0;
  logic          sample, strobe, busy, hit_dropped, event_valid;
  logic [AB-1:0] dac_word;
  logic [EW-1:0] event_data;
  real           vin = 0.0;

  int n_cmp = 0;
  int n_err = 0;

  int            drops = 0, samp_cyc = 0, hs_cnt = 0;
  logic [AB-1:0] trials[$];
  int            tr_base, s_base;

  sar_channel_ctrl #(
    .ADCBITS(AB), .TIME_STAMP_W(TW), .CHANNEL_ID_W(CW),
    .CHANNEL_ID(CH), .SAMPLE_CYCLES(SC)
  ) dut (
    .clk4x(clk4x), .reset(reset), .arm(arm), .hit(hit),
    .timestamp(timestamp), .comp(comp), .sample(sample), .strobe(strobe),
    .dac_word(dac_word), .busy(busy), .hit_dropped(hit_dropped),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_data(event_data)
  );

  always #5 clk4x = ~clk4x;

  always @(posedge clk4x) timestamp <= timestamp + 1'b1;

  function automatic bit cmp_model(input real v, input logic [AB-1:0] d);
    return v >= 0.5 + (0.5 * d) / 64.0;
  endfunction

  // Largest code whose DAC level does not exceed vin.
  function automatic int ref_code(input real v);
    int c = 0;
    for (int i = 0; i < 64; i++)
      if (cmp_model(v, AB'(i))) c = i;
    return c;
  endfunction

  always_comb comp = strobe && cmp_model(vin, dac_word);

  always @(negedge clk4x) begin
    if (strobe) trials.push_back(dac_word);
    if (hit_dropped) drops++;
    if (sample) samp_cyc++;
    if (event_valid && event_ready) hs_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk4x);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sample"}, sample, 0);
    chk({tag, "_strobe"}, strobe, 0);
    chk({tag, "_dac"}, dac_word, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_drop"}, hit_dropped, 0);
    chk({tag, "_valid"}, event_valid, 0);
    chk({tag, "_data"}, event_data, 0);
  endtask

  task automatic start_hit(input real v, output logic [TW-1:0] ts_exp);
    vin     = v;
    hit     = 1'b1;
    ts_exp  = timestamp;
    tr_base = trials.size();
    s_base  = samp_cyc;
  endtask

  task automatic wait_valid(input int arm_off_at, output int lat);
    int n = 0;
    while (!event_valid && n < 100) begin
      tick();
      n++;
      if (n == arm_off_at) arm = 1'b0;
    end
    chk("valid_timeout", event_valid, 1);
    lat = n - 1;
  endtask

  task automatic check_event(input real v, input logic [TW-1:0] ts_exp, input int lat);
    int code = ref_code(v);
    chk("latency", lat, LAT);
    chk("ch_field", event_data[EW-1:TW+AB], CH);
    chk("ts_field", event_data[TW+AB-1:AB], ts_exp);
    chk("code", event_data[AB-1:0], code);
    chk("dac_final", dac_word, code);
    chk("n_trials", trials.size() - tr_base, AB);
    if (trials.size() > tr_base) chk("first_trial", trials[tr_base], 32);
    chk("sample_cycles", samp_cyc - s_base, SC);
  endtask

  task automatic finish_hs();
    tick();
    chk("valid_clr", event_valid, 0);
    chk("busy_clr", busy, 0);
  endtask

  initial begin
    logic [TW-1:0] ts;
    logic [EW-1:0] held;
    int            lat, d0, h0, s0, n, sc;
    real           edge_v[3];
    int            seq[6];

    edge_v = '{1.0, 0.5, 0.49};
    seq    = '{32, 48, 40, 36, 34, 33};

    reset = 1'b1; arm = 1'b1; hit = 1'b0; event_ready = 1'b1;
    repeat (3) tick();
    check_zero("rst");
    reset = 1'b0;
    tick();

    // Directed conversion at time stamp 100
    n = 0;
    while (timestamp != 100 && n < 300) begin tick(); n++; end
    d0 = drops;
    start_hit(0.76, ts);
    wait_valid(0, lat);
    check_event(0.76, ts, lat);
    chk("ts100", event_data[TW+AB-1:AB], 100);
    chk("code33", event_data[AB-1:0], 33);
    for (int i = 0; i < 6; i++)
      if (trials.size() > tr_base + i) chk("dac_seq", trials[tr_base + i], seq[i]);
    finish_hs();
    chk("no_drop", drops - d0, 0);
    hit = 1'b0; tick();

    // Range ends
    for (int i = 0; i < 3; i++) begin
      start_hit(edge_v[i], ts);
      wait_valid(0, lat);
      check_event(edge_v[i], ts, lat);
      finish_hs();
      hit = 1'b0; tick();
    end

    // Back-pressure with a re-trigger while the event is held
    event_ready = 1'b0;
    d0 = drops; h0 = hs_cnt;
    start_hit(0.6, ts);
    wait_valid(0, lat);
    check_event(0.6, ts, lat);
    held = event_data;
    tick();
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 3) hit = 1'b1;
      chk("held_data", event_data, held);
      chk("held_valid", event_valid, 1);
    end
    chk("bp_drops", drops - d0, 1);
    chk("bp_no_hs", hs_cnt - h0, 0);
    event_ready = 1'b1;
    finish_hs();
    hit = 1'b0; tick();
    chk("bp_one_event", hs_cnt - h0, 1);

    // Disarmed hit is ignored silently
    arm = 1'b0;
    d0 = drops; h0 = hs_cnt; s0 = samp_cyc;
    hit = 1'b1;
    repeat (20) tick();
    hit = 1'b0; tick();
    chk("disarm_busy", busy, 0);
    chk("disarm_sample", samp_cyc - s0, 0);
    chk("disarm_event", hs_cnt - h0, 0);
    chk("disarm_drop", drops - d0, 0);
    arm = 1'b1;

    // arm removed mid-conversion
    start_hit(0.83, ts);
    wait_valid(5, lat);
    check_event(0.83, ts, lat);
    finish_hs();
    hit = 1'b0; arm = 1'b1; tick();

    // hit held high: one event, then a one-cycle low re-triggers
    h0 = hs_cnt; d0 = drops;
    start_hit(0.7, ts);
    wait_valid(0, lat);
    check_event(0.7, ts, lat);
    finish_hs();
    repeat (33) tick();
    chk("held_one_event", hs_cnt - h0, 1);
    chk("held_no_drop", drops - d0, 0);
    hit = 1'b0; tick();
    start_hit(0.9, ts);
    wait_valid(0, lat);
    check_event(0.9, ts, lat);
    finish_hs();
    hit = 1'b0; tick();
    chk("retrig_event", hs_cnt - h0, 2);

    // Reset during the CHECK of bit 3
    start_hit(0.66, ts);
    sc = 0; n = 0;
    while (sc < 3 && n < 100) begin
      tick(); n++;
      if (strobe) sc++;
    end
    chk("reach_bit3", sc, 3);
    reset = 1'b1;
    tick();
    check_zero("midrst");
    reset = 1'b0; hit = 1'b0;
    tick(); tick();
    start_hit(0.55, ts);
    wait_valid(0, lat);
    check_event(0.55, ts, lat);
    finish_hs();
    hit = 1'b0; tick();

    // Random levels and gaps
    for (int r = 0; r < 10; r++) begin
      real v;
      repeat ($urandom_range(1, 8)) tick();
      v = 0.45 + $urandom_range(0, 620) / 1000.0;
      start_hit(v, ts);
      wait_valid(0, lat);
      check_event(v, ts, lat);
      finish_hs();
      hit = 1'b0; tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
